// File: rtl/my_arb2x16_pkg.sv
// Shared definitions for the my_arb2x16 two-input arbiter.
// Holds the data width, the run-counter width, the EMPTY/FULL output-stage
// state encoding and the saturating run-counter helper.
package my_arb2x16_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned RunWidth  = 4;

  // Output stage state: EMPTY means no beat held, FULL means out_valid is high.
  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  typedef logic [DataWidth-1:0] data_t;
  typedef logic [RunWidth-1:0]  run_t;

  // Consecutive-grant count, saturating at the burst limit.
  function automatic run_t run_next(run_t run, run_t burst);
    return (run >= burst) ? burst : run + 1'b1;
  endfunction

endpackage

// File: rtl/my_arb2x16_if.sv
// Handshake bundle for my_arb2x16: two requester channels (valid/data/ready)
// and one registered output channel (valid/data/ready/src).
// Modports:
//   master - requester/consumer side (drives in*_valid, in*_data, out_ready)
//   slave  - arbiter side (drives in*_ready, out_valid, out_data, out_src)
interface my_arb2x16_if;
  import my_arb2x16_pkg::*;

  logic  in0_valid;
  data_t in0_data;
  logic  in0_ready;
  logic  in1_valid;
  data_t in1_data;
  logic  in1_ready;
  logic  out_valid;
  data_t out_data;
  logic  out_ready;
  logic  out_src;

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/my_mux16.sv
// Gate-level 16-bit 2:1 multiplexer.
// Ports:
//   in1 - selected when sel = 0
//   in2 - selected when sel = 1
//   sel - select
//   out - selected word
module my_mux16 (
  input  wire [15:0] in1,
  input  wire [15:0] in2,
  input  wire        sel,
  output wire [15:0] out
);

  wire sel_n;

  not u_inv (sel_n, sel);

  for (genvar i = 0; i < 16; i++) begin : g_bit
    wire a;
    wire b;
    and u_and_a (a, in1[i], sel_n);
    and u_and_b (b, in2[i], sel);
    or  u_or    (out[i], a, b);
  end

endmodule

// File: rtl/my_arb2x16.sv
// Two-requester, 16-bit arbiter with a single registered output stage.
// Grants alternate between requesters after at most BURST consecutive grants
// to one while the other waits; a lone requester is granted every cycle.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - my_arb2x16_if.slave: requester channels 0/1 and output channel
//   cnt0, cnt1 - per-requester accepted-beat counters (only when the macro
//                MY_ARB2X16_CNT_EN is defined)
// Parameter BURST: max consecutive grants under contention, 1..15.
module my_arb2x16
  import my_arb2x16_pkg::*;
#(
  parameter int unsigned BURST = 2
) (
  input logic        clk,
  input logic        reset,
  my_arb2x16_if.slave bus
`ifdef MY_ARB2X16_CNT_EN
  ,
  output logic [DataWidth-1:0] cnt0,
  output logic [DataWidth-1:0] cnt1
`endif
);

  localparam run_t BurstRun = run_t'(BURST);

  logic       state_q, state_d;
  data_t      data_q, data_d;
  logic       src_q, src_d;
  logic       last_q, last_d;
  run_t       run_q, run_d;

  logic       load;
  logic       grant;
  logic       grant_vld;
  logic       xfer;
  data_t      sel_data;

  my_mux16 u_mux (
    .in1 (bus.in0_data),
    .in2 (bus.in1_data),
    .sel (grant),
    .out (sel_data)
  );

  always_comb begin
    grant     = 1'b0;
    grant_vld = 1'b1;
    unique case ({bus.in1_valid, bus.in0_valid})
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      // Contention: stay with the last winner until its run hits the limit.
      2'b11:   grant = (run_q < BurstRun) ? last_q : ~last_q;
      default: grant_vld = 1'b0;
    endcase
  end

  assign load          = (state_q == StEmpty) | bus.out_ready;
  assign xfer          = load & grant_vld & ~reset;
  assign bus.in0_ready = xfer & ~grant;
  assign bus.in1_ready = xfer & grant;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    run_d   = run_q;
    if (xfer) begin
      state_d = StFull;
      data_d  = sel_data;
      src_d   = grant;
      if (grant == last_q) begin
        run_d = run_next(run_q, BurstRun);
      end else begin
        last_d = grant;
        run_d  = run_t'(1);
      end
    end else if (bus.out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      src_q   <= 1'b0;
      // last=1 with a saturated run makes the first contention go to requester 0.
      last_q  <= 1'b1;
      run_q   <= BurstRun;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      run_q   <= run_d;
    end
  end

  assign bus.out_valid = (state_q == StFull);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

`ifdef MY_ARB2X16_CNT_EN
  data_t cnt0_q, cnt0_d;
  data_t cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (bus.in0_ready) cnt0_d = cnt0_q + 16'd1;
    if (bus.in1_ready) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
